// File: rtl/sys_reset_seq_if.sv
// Bundle of sequencer control and status signals shared between the reset sequencer
// and the timer channels it drives.
interface sys_reset_seq_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    logic [NUM_CH*DIV_W-1:0] div_val;
    logic                    soft_rst_req;
    logic                    soft_rst_ack;
    logic [NUM_CH-1:0]       ch_rst;
    logic [NUM_CH-1:0]       ch_tick;
    logic                    seq_busy;

    modport master (
        output div_val,
        output soft_rst_req,
        input  soft_rst_ack,
        input  ch_rst,
        input  ch_tick,
        input  seq_busy
    );

    modport slave (
        input  div_val,
        input  soft_rst_req,
        output soft_rst_ack,
        output ch_rst,
        output ch_tick,
        output seq_busy
    );
endinterface

// File: rtl/sys_reset_seq.sv
// Staggered per-channel reset release plus per-channel programmable clock-enable ticks
// for the APB timer subsystem.
module sys_reset_seq #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 8,
    parameter int HOLD_CYC = 16,
    parameter int STAGGER  = 4
) (
    input logic            sys_clk,
    input logic            sys_reset,
    sys_reset_seq_if.slave bus
);
    localparam int MAX_CYC = (HOLD_CYC > STAGGER) ? HOLD_CYC : STAGGER;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

    state_t            state;
    logic [CNT_W-1:0]  seq_cnt;
    logic [IDX_W-1:0]  ch_idx;
    logic [NUM_CH-1:0] ch_rst_r;
    logic [NUM_CH-1:0] ch_tick_r;
    logic              busy_r;
    logic              ack_r;
    logic [NUM_CH-1:0] rel_vec;
    logic              soft_go;
    logic [DIV_W-1:0]  div_cnt [NUM_CH];

    // rel_vec marks the channel whose reset is cleared on this edge
    always_comb begin
        rel_vec = '0;
        soft_go = 1'b0;
        if (!sys_reset) begin
            case (state)
                HOLD: begin
                    if (seq_cnt == CNT_W'(HOLD_CYC - 1)) rel_vec[0] = 1'b1;
                end
                RELEASE: begin
                    if (seq_cnt == CNT_W'(STAGGER - 1)) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (ch_idx == IDX_W'(i)) rel_vec[i] = 1'b1;
                        end
                    end
                end
                RUN:     soft_go = bus.soft_rst_req;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        ack_r <= 1'b0;
        if (sys_reset) begin
            state    <= HOLD;
            seq_cnt  <= '0;
            ch_idx   <= '0;
            ch_rst_r <= '1;
            busy_r   <= 1'b1;
        end else begin
            ch_rst_r <= ch_rst_r & ~rel_vec;
            case (state)
                HOLD: begin
                    if (rel_vec[0]) begin
                        seq_cnt <= '0;
                        ch_idx  <= IDX_W'(1);
                        if (NUM_CH == 1) begin
                            state  <= RUN;
                            busy_r <= 1'b0;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        seq_cnt <= seq_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (|rel_vec) begin
                        seq_cnt <= '0;
                        ch_idx  <= ch_idx + 1'b1;
                        if (ch_idx == IDX_W'(NUM_CH - 1)) begin
                            state  <= RUN;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        seq_cnt <= seq_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (soft_go) begin
                        ack_r    <= 1'b1;
                        ch_rst_r <= '1;
                        busy_r   <= 1'b1;
                        seq_cnt  <= '0;
                        ch_idx   <= '0;
                        state    <= HOLD;
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

    // Divisor is sampled only at release and at each reload, so a change never cuts a period short
    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (sys_reset || soft_go) begin
                div_cnt[i]   <= '0;
                ch_tick_r[i] <= 1'b0;
            end else if (rel_vec[i]) begin
                div_cnt[i]   <= bus.div_val[i*DIV_W +: DIV_W];
                ch_tick_r[i] <= 1'b0;
            end else if (ch_rst_r[i]) begin
                div_cnt[i]   <= '0;
                ch_tick_r[i] <= 1'b0;
            end else if (div_cnt[i] == '0) begin
                div_cnt[i]   <= bus.div_val[i*DIV_W +: DIV_W];
                ch_tick_r[i] <= 1'b1;
            end else begin
                div_cnt[i]   <= div_cnt[i] - 1'b1;
                ch_tick_r[i] <= 1'b0;
            end
        end
    end

    assign bus.ch_rst       = ch_rst_r;
    assign bus.ch_tick      = ch_tick_r;
    assign bus.seq_busy     = busy_r;
    assign bus.soft_rst_ack = ack_r;
endmodule

// File: tb/tb_sys_reset_seq.sv
// Scoreboard bench for sys_reset_seq: an event-scheduling model predicts every cycle's
// outputs and a monitor compares them against the DUT.
module tb_sys_reset_seq;
    localparam int NUM_CH   = 4;
    localparam int DIV_W    = 8;
    localparam int HOLD_CYC = 16;
    localparam int STAGGER  = 4;

    typedef struct packed {
        logic [NUM_CH-1:0] rst;
        logic [NUM_CH-1:0] tick;
        logic              busy;
        logic              ack;
    } obs_t;

    logic sys_clk;
    logic sys_reset;
    logic [NUM_CH*DIV_W-1:0] dv;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   seq_t = 0;
    int   next_tick [NUM_CH];

    sys_reset_seq_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    sys_reset_seq #(
        .NUM_CH  (NUM_CH),
        .DIV_W   (DIV_W),
        .HOLD_CYC(HOLD_CYC),
        .STAGGER (STAGGER)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_reset(sys_reset),
        .bus      (bus.slave)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic int rel_edge(input int i);
        return HOLD_CYC + i * STAGGER;
    endfunction

    // seq_t counts edges since the sequence (re)started; releases and ticks are scheduled events
    task automatic model_edge(input bit rst, input bit req);
        obs_t e;
        int   d;
        e.rst  = '1;
        e.tick = '0;
        e.busy = 1'b1;
        e.ack  = 1'b0;
        if (rst) begin
            seq_t = 0;
        end else if (req && seq_t >= rel_edge(NUM_CH - 1)) begin
            seq_t = 0;
            e.ack = 1'b1;
        end else begin
            seq_t++;
            for (int i = 0; i < NUM_CH; i++) begin
                d = int'(dv[i*DIV_W +: DIV_W]);
                if (seq_t >= rel_edge(i)) begin
                    e.rst[i] = 1'b0;
                    if (seq_t == rel_edge(i)) begin
                        next_tick[i] = seq_t + d + 1;
                    end else if (seq_t == next_tick[i]) begin
                        e.tick[i]    = 1'b1;
                        next_tick[i] = seq_t + d + 1;
                    end
                end
            end
            e.busy = |e.rst;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rst, input bit req);
        sys_reset        = rst;
        bus.soft_rst_req = req;
        bus.div_val      = dv;
        model_edge(rst, req);
        @(negedge sys_clk);
    endtask

    initial begin : monitor
        obs_t e;
        obs_t got;
        forever begin
            @(posedge sys_clk);
            #1;
            cyc++;
            got.rst  = bus.ch_rst;
            got.tick = bus.ch_tick;
            got.busy = bus.seq_busy;
            got.ack  = bus.soft_rst_ack;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL no_expectation cyc%0d: got %b, required a queued expectation", cyc, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL outputs cyc%0d: got rst=%b tick=%b busy=%b ack=%b, required rst=%b tick=%b busy=%b ack=%b",
                             cyc, got.rst, got.tick, got.busy, got.ack, e.rst, e.tick, e.busy, e.ack);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, required stimulus to complete");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit r;
        bit q;
        dv = '0;
        dv[0*DIV_W +: DIV_W] = 8'd0;
        dv[1*DIV_W +: DIV_W] = 8'd3;
        dv[2*DIV_W +: DIV_W] = 8'd255;
        dv[3*DIV_W +: DIV_W] = 8'd7;

        // power-up with a request held through HOLD/RELEASE that must be ignored
        repeat (5)  step(1'b1, 1'b0);
        repeat (27) step(1'b0, 1'b1);
        repeat (22) step(1'b0, 1'b0);

        // divisor change mid-period on channel 1, long enough to see two channel-2 periods
        dv[1*DIV_W +: DIV_W] = 8'd9;
        repeat (600) step(1'b0, 1'b0);

        // soft reset in RUN
        step(1'b0, 1'b1);
        repeat (50) step(1'b0, 1'b0);

        // sys_reset pulsed at edge 22 of a fresh sequence
        repeat (2)  step(1'b1, 1'b0);
        repeat (21) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (60) step(1'b0, 1'b0);

        // sys_reset and soft request on the same edge in RUN
        step(1'b1, 1'b1);
        repeat (40) step(1'b0, 1'b0);

        // randomized divisors, requests and resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0)
                dv[$urandom_range(0, NUM_CH - 1) * DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 12));
            r = ($urandom_range(0, 299) == 0);
            q = ($urandom_range(0, 39) == 0);
            step(r, q);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
